gerador_pulso_saida: RTL and testbench



---
 rtl/gerador_pkg.sv | 13 +
 rtl/contador_intervalo.sv | 38 +++
 rtl/gerador_pulso_saida.sv | 139 +++++++++++++
 tb/tb_gerador_pulso_saida.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gerador_pkg.sv
// Shared types and constants for the output pulse generator.
package gerador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } estado_t;

  localparam int CLK_HZ = 50_000_000;
  localparam int T_10MS = 500_000;

endpackage

// File: rtl/contador_intervalo.sv
// Loadable interval up-counter shared by the ON and GAP phases.
// fim_o flags the last cycle of an interval of limite_i cycles.
module contador_intervalo #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          carregar_i,
  input  logic          incrementar_i,
  input  logic [CW-1:0] limite_i,
  output logic          fim_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign fim_o = (cnt_q == (limite_i - CW'(1)));

  // Next count: reload to zero, otherwise count up and hold at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (carregar_i) begin
      cnt_d = '0;
    end else if (incrementar_i && !fim_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gerador_pulso_saida.sv
// Turns single-cycle event flags into fixed-width output pulses, each
// followed by a dead time; events arriving while busy are queued in a
// saturating counter and replayed back-to-back.
//
//   state | meaning
//   IDLE  | output low, nothing pending, waiting for an event
//   ON    | output high for ON_CYCLES cycles
//   GAP   | output low for OFF_CYCLES cycles (dead time)
module gerador_pulso_saida
  import gerador_pkg::*;
#(
  parameter int ON_CYCLES  = T_10MS,
  parameter int OFF_CYCLES = T_10MS,
  parameter int MAX_PEND   = 15,
  parameter int CW = $clog2(((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES) + 1),
  parameter int PW = $clog2(MAX_PEND + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flag_evento,
  output logic          saida,
  output logic          ocupado,
  output logic [PW-1:0] pendentes,
  output logic          estouro
);

  localparam logic [CW-1:0] LIM_ON  = CW'(ON_CYCLES);
  localparam logic [CW-1:0] LIM_OFF = CW'(OFF_CYCLES);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);

  estado_t       estado_q, estado_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          saida_q, ocupado_q, estouro_q, estouro_d;

  logic          carregar, incrementar, fim;
  logic          consumido, retirar, enfileirar;
  logic [CW-1:0] limite;

  // The interval length follows the phase the counter is currently timing.
  assign limite      = (estado_q == GAP) ? LIM_OFF : LIM_ON;
  assign incrementar = (estado_q != IDLE);

  contador_intervalo #(
    .CW(CW)
  ) u_contador (
    .clk           (clk),
    .rst           (rst),
    .carregar_i    (carregar),
    .incrementar_i (incrementar),
    .limite_i      (limite),
    .fim_o         (fim)
  );

  // Next-state decode; the counter is reloaded on every phase change.
  always_comb begin
    estado_d  = estado_q;
    carregar  = 1'b0;
    consumido = 1'b0;
    retirar   = 1'b0;
    case (estado_q)
      IDLE: begin
        carregar = 1'b1;
        if (flag_evento) begin
          estado_d  = ON;
          consumido = 1'b1;
        end else if (pend_q != '0) begin
          estado_d = ON;
          retirar  = 1'b1;
        end
      end
      ON: begin
        if (fim) begin
          estado_d = GAP;
          carregar = 1'b1;
        end
      end
      GAP: begin
        if (fim) begin
          carregar = 1'b1;
          if (pend_q != '0) begin
            estado_d = ON;
            retirar  = 1'b1;
          end else if (flag_evento) begin
            estado_d  = ON;
            consumido = 1'b1;
          end else begin
            estado_d = IDLE;
          end
        end
      end
      default: begin
        estado_d = IDLE;
        carregar = 1'b1;
      end
    endcase
  end

  // A busy-time event not started directly goes into the queue.
  assign enfileirar = flag_evento && !consumido && (estado_q != IDLE);

  // Pending queue: a simultaneous enqueue and replay nets to no change and
  // never overflows, since a slot is being freed in that same cycle.
  always_comb begin
    pend_d    = pend_q;
    estouro_d = 1'b0;
    if (enfileirar && !retirar) begin
      if (pend_q == PEND_MAX) begin
        estouro_d = 1'b1;
      end else begin
        pend_d = pend_q + PW'(1);
      end
    end else if (retirar && !enfileirar) begin
      pend_d = pend_q - PW'(1);
    end
  end

  // State and registered outputs, all updated on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q  <= IDLE;
      pend_q    <= '0;
      saida_q   <= 1'b0;
      ocupado_q <= 1'b0;
      estouro_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      pend_q    <= pend_d;
      saida_q   <= (estado_d == ON);
      ocupado_q <= (estado_d != IDLE);
      estouro_q <= estouro_d;
    end
  end

  assign saida     = saida_q;
  assign ocupado   = ocupado_q;
  assign pendentes = pend_q;
  assign estouro   = estouro_q;

endmodule

// File: tb/tb_gerador_pulso_saida.sv
// Bench for gerador_pulso_saida. The reference model schedules each accepted
// event as a pulse start time and derives every output from that schedule.
module tb_gerador_pulso_saida;

  localparam int ON   = 4;
  localparam int OFF  = 3;
  localparam int MAXP = 2;
  localparam int PW   = $clog2(MAXP + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flag_evento = 1'b0;
  logic          saida, ocupado, estouro;
  logic [PW-1:0] pendentes;

  int checks = 0;
  int errors = 0;
  int t = 0;

  int acc_flag[$];
  int acc_start[$];
  int drop_at[$];
  int next_start = 0;

  gerador_pulso_saida #(
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF),
    .MAX_PEND  (MAXP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flag_evento(flag_evento),
    .saida      (saida),
    .ocupado    (ocupado),
    .pendentes  (pendentes),
    .estouro    (estouro)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int pend_at(int c);
    int n = 0;
    foreach (acc_start[k]) if (acc_flag[k] < c && acc_start[k] > c) n++;
    return n;
  endfunction

  function automatic bit saida_at(int c);
    foreach (acc_start[k]) if (c >= acc_start[k] && c < acc_start[k] + ON) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit ocup_at(int c);
    foreach (acc_start[k]) if (c >= acc_start[k] && c < acc_start[k] + ON + OFF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit est_at(int c);
    foreach (drop_at[k]) if (drop_at[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_event(int c);
    bit freeing = 1'b0;
    int s;
    foreach (acc_start[k]) if (acc_start[k] == c + 1) freeing = 1'b1;
    if (pend_at(c) == MAXP && !freeing) begin
      drop_at.push_back(c + 1);
    end else begin
      s = (c + 1 > next_start) ? c + 1 : next_start;
      acc_flag.push_back(c);
      acc_start.push_back(s);
      next_start = s + ON + OFF;
    end
  endfunction

  function automatic void model_clear();
    acc_flag.delete();
    acc_start.delete();
    drop_at.delete();
    next_start = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    flag_evento = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({saida, ocupado, pendentes, estouro} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got saida=%b ocupado=%b pend=%0d estouro=%b required all 0",
               saida, ocupado, pendentes, estouro);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    t = 0;
    model_clear();
  endtask

  task automatic test_single();
    int hi = 0;
    for (int i = 0; i < 30; i++) begin
      flag_evento = (i == 10);
      @(negedge clk);
      checks++;
      if (saida !== saida_at(t)) begin errors++; $display("FAIL single_saida i=%0d got %b required %b", i, saida, saida_at(t)); end
      checks++;
      if (ocupado !== ocup_at(t)) begin errors++; $display("FAIL single_ocupado i=%0d got %b required %b", i, ocupado, ocup_at(t)); end
      checks++;
      if (pendentes !== 0) begin errors++; $display("FAIL single_pend i=%0d got %0d required 0", i, pendentes); end
      if (saida) hi++;
      if (i == 18) begin
        checks++;
        if (ocupado !== 1'b0) begin errors++; $display("FAIL single_ocupado_end got %b required 0", ocupado); end
      end
      if (flag_evento) model_event(t);
      tick();
    end
    flag_evento = 1'b0;
    checks++;
    if (hi != ON) begin errors++; $display("FAIL single_width got %0d required %0d", hi, ON); end
  endtask

  task automatic test_queued();
    int ups = 0;
    bit prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      flag_evento = (i == 10 || i == 12 || i == 16);
      @(negedge clk);
      checks++;
      if (saida !== saida_at(t)) begin errors++; $display("FAIL queued_saida i=%0d got %b required %b", i, saida, saida_at(t)); end
      checks++;
      if (pendentes !== PW'(pend_at(t))) begin errors++; $display("FAIL queued_pend i=%0d got %0d required %0d", i, pendentes, pend_at(t)); end
      checks++;
      if (ocupado !== ocup_at(t)) begin errors++; $display("FAIL queued_ocupado i=%0d got %b required %b", i, ocupado, ocup_at(t)); end
      if (i == 13 || i == 17 || i == 25) begin
        checks++;
        if (pendentes !== PW'((i == 13) ? 1 : (i == 17) ? 2 : 0)) begin
          errors++; $display("FAIL queued_pend_point i=%0d got %0d", i, pendentes);
        end
      end
      if (saida && !prev) begin
        checks++;
        if (!(i == 11 || i == 18 || i == 25)) begin errors++; $display("FAIL queued_start got i=%0d required 11/18/25", i); end
        ups++;
      end
      prev = saida;
      if (flag_evento) model_event(t);
      tick();
    end
    flag_evento = 1'b0;
    checks++;
    if (ups != 3) begin errors++; $display("FAIL queued_count got %0d required 3", ups); end
  endtask

  task automatic test_overflow();
    int ups = 0, ests = 0;
    bit prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      flag_evento = (i <= 3);
      @(negedge clk);
      checks++;
      if (estouro !== est_at(t)) begin errors++; $display("FAIL ovf_estouro i=%0d got %b required %b", i, estouro, est_at(t)); end
      checks++;
      if (pendentes !== PW'(pend_at(t))) begin errors++; $display("FAIL ovf_pend i=%0d got %0d required %0d", i, pendentes, pend_at(t)); end
      checks++;
      if (saida !== saida_at(t)) begin errors++; $display("FAIL ovf_saida i=%0d got %b required %b", i, saida, saida_at(t)); end
      if (saida && !prev) ups++;
      if (estouro) ests++;
      prev = saida;
      if (flag_evento) model_event(t);
      tick();
    end
    flag_evento = 1'b0;
    checks++;
    if (ups != 3) begin errors++; $display("FAIL ovf_pulses got %0d required 3", ups); end
    checks++;
    if (ests != 1) begin errors++; $display("FAIL ovf_estouro_count got %0d required 1", ests); end
  endtask

  task automatic test_direct_gap();
    for (int i = 0; i < 25; i++) begin
      flag_evento = (i == 0 || i == 7);
      @(negedge clk);
      checks++;
      if (saida !== saida_at(t)) begin errors++; $display("FAIL direct_saida i=%0d got %b required %b", i, saida, saida_at(t)); end
      checks++;
      if (ocupado !== ocup_at(t)) begin errors++; $display("FAIL direct_ocupado i=%0d got %b required %b", i, ocupado, ocup_at(t)); end
      if (i >= 1 && i <= 14) begin
        checks++;
        if (ocupado !== 1'b1 || pendentes !== 0) begin
          errors++; $display("FAIL direct_no_idle i=%0d got ocupado=%b pend=%0d required 1/0", i, ocupado, pendentes);
        end
      end
      if (i == 8) begin
        checks++;
        if (saida !== 1'b1) begin errors++; $display("FAIL direct_start got %b required 1", saida); end
      end
      if (flag_evento) model_event(t);
      tick();
    end
    flag_evento = 1'b0;
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 45; i++) begin
      flag_evento = (i <= 2 || i == 7);
      @(negedge clk);
      checks++;
      if (pendentes !== PW'(pend_at(t))) begin errors++; $display("FAIL simul_pend i=%0d got %0d required %0d", i, pendentes, pend_at(t)); end
      checks++;
      if (estouro !== est_at(t)) begin errors++; $display("FAIL simul_estouro i=%0d got %b required %b", i, estouro, est_at(t)); end
      checks++;
      if (saida !== saida_at(t)) begin errors++; $display("FAIL simul_saida i=%0d got %b required %b", i, saida, saida_at(t)); end
      if (i == 8) begin
        checks++;
        if (pendentes !== PW'(2) || estouro !== 1'b0) begin
          errors++; $display("FAIL simul_point got pend=%0d estouro=%b required 2/0", pendentes, estouro);
        end
      end
      if (flag_evento) model_event(t);
      tick();
    end
    flag_evento = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    int hi = 0;
    flag_evento = 1'b1;
    tick();              // cycle: first ON
    flag_evento = 1'b0;  // one more event queued from previous cycle? no: queue now
    flag_evento = 1'b1;
    tick();              // cycle: second ON, one event pending
    flag_evento = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (saida !== 1'b0 || ocupado !== 1'b0 || pendentes !== 0) begin
      errors++;
      $display("FAIL reset_async got saida=%b ocupado=%b pend=%0d required 0/0/0", saida, ocupado, pendentes);
    end
    model_clear();
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      flag_evento = (i == 0);
      @(negedge clk);
      checks++;
      if (saida !== saida_at(t)) begin errors++; $display("FAIL rst_pulse_saida i=%0d got %b required %b", i, saida, saida_at(t)); end
      if (i == 1) begin
        checks++;
        if (saida !== 1'b1) begin errors++; $display("FAIL rst_first_edge got %b required 1", saida); end
      end
      if (saida) hi++;
      if (flag_evento) model_event(t);
      tick();
    end
    flag_evento = 1'b0;
    checks++;
    if (hi != ON) begin errors++; $display("FAIL rst_pulse_width got %0d required %0d", hi, ON); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      flag_evento = (i < 370) && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      checks++;
      if (saida !== saida_at(t)) begin errors++; $display("FAIL rand_saida t=%0d got %b required %b", t, saida, saida_at(t)); end
      checks++;
      if (ocupado !== ocup_at(t)) begin errors++; $display("FAIL rand_ocupado t=%0d got %b required %b", t, ocupado, ocup_at(t)); end
      checks++;
      if (pendentes !== PW'(pend_at(t))) begin errors++; $display("FAIL rand_pend t=%0d got %0d required %0d", t, pendentes, pend_at(t)); end
      checks++;
      if (estouro !== est_at(t)) begin errors++; $display("FAIL rand_estouro t=%0d got %b required %b", t, estouro, est_at(t)); end
      if (flag_evento) model_event(t);
      tick();
    end
    flag_evento = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_queued();
    test_overflow();
    test_direct_gap();
    test_simultaneous();
    test_reset_mid_pulse();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
